// File: rtl/decode_stage_pkg.sv
// Shared decode constants: MIPS opcode/funct encodings, ALU operation codes
// and the control bundle carried in the ID/EX register.
package decode_stage_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    alu_src;
      logic    branch;
      logic    jump;
      alu_op_e alu_op;
   } ctrl_t;

   // All controls inactive: what a bubble carries into execute.
   localparam ctrl_t CTRL_NONE = ctrl_t'('0);

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational MIPS decoder: instruction word to controls, ALU op,
// destination register, operand usage, illegal flag and extended immediate.
module instr_decoder
   import decode_stage_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic [31:0]           instruction,
   output ctrl_t                 ctrl,
   output logic [REG_ADDR_W-1:0] dest,
   output logic                  uses_rs,
   output logic                  uses_rt,
   output logic                  illegal,
   output logic [DATA_W-1:0]     imm
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       sign_ext;

   assign opcode = instruction[31:26];
   assign funct  = instruction[5:0];

   // Decode opcode/funct into the control bundle and operand usage.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
      ctrl     = CTRL_NONE;
      dest     = '0;
      uses_rs  = 1'b1;
      uses_rt  = 1'b0;
      illegal  = 1'b0;
      sign_ext = 1'b1;
      unique case (opcode)
         OP_RTYPE: begin
            uses_rt = 1'b1;
            if (instruction != 32'h0) begin
               ctrl.reg_write = 1'b1;
               dest           = REG_ADDR_W'(instruction[15:11]);
               unique case (funct)
                  FN_ADD:  ctrl.alu_op = ALU_ADD;
                  FN_SUB:  ctrl.alu_op = ALU_SUB;
                  FN_AND:  ctrl.alu_op = ALU_AND;
                  FN_OR:   ctrl.alu_op = ALU_OR;
                  FN_SLT:  ctrl.alu_op = ALU_SLT;
                  default: illegal     = 1'b1;
               endcase
            end
         end
         OP_ADDI, OP_SLTI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            dest           = REG_ADDR_W'(instruction[20:16]);
         end
         OP_ANDI, OP_ORI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
            dest           = REG_ADDR_W'(instruction[20:16]);
            sign_ext       = 1'b0;
         end
         OP_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_src    = 1'b1;
            dest            = REG_ADDR_W'(instruction[20:16]);
         end
         OP_SW: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            uses_rt        = 1'b1;
         end
         OP_BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALU_SUB;
            uses_rt     = 1'b1;
         end
         OP_J: begin
            ctrl.jump = 1'b1;
            uses_rs   = 1'b0;
         end
         default: illegal = 1'b1;
      endcase
      // An illegal word travels as a bubble; a non-writing word names no destination.
      if (illegal) begin
         ctrl = CTRL_NONE;
      end
      if (!ctrl.reg_write) begin
         dest = '0;
      end
   end

   assign imm = sign_ext ? {{(DATA_W-16){instruction[15]}}, instruction[15:0]}
                         : {{(DATA_W-16){1'b0}}, instruction[15:0]};

endmodule

// File: rtl/decode_stage.sv
// Pipelined MIPS instruction-decode stage: register-bank addressing, ID/EX
// register, load-use bubble insertion, branch flush and valid/ready handshake.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   InstrValid,
   input  logic [31:0]            Instruction,
   output logic                   InstrReady,
   output logic [REG_ADDR_W-1:0]  ReadRegister1,
   output logic [REG_ADDR_W-1:0]  ReadRegister2,
   input  logic [DATA_W-1:0]      ReadData1,
   input  logic [DATA_W-1:0]      ReadData2,
   input  logic                   Flush,
   input  logic                   OutReady,
   output logic                   OutValid,
   output logic [DATA_W-1:0]      OutData1,
   output logic [DATA_W-1:0]      OutData2,
   output logic [DATA_W-1:0]      OutImm,
   output logic [4:0]             OutShamt,
   output logic [REG_ADDR_W-1:0]  OutDest,
   output logic [2:0]             OutAluOp,
   output logic                   OutRegWrite,
   output logic                   OutMemRead,
   output logic                   OutMemWrite,
   output logic                   OutMemToReg,
   output logic                   OutAluSrc,
   output logic                   OutBranch,
   output logic                   OutJump,
   output logic [25:0]            OutJumpTarget,
   output logic                   IllegalSeen,
   output logic [STALL_CNT_W-1:0] StallCount
);

   ctrl_t                 dec_ctrl;
   logic [REG_ADDR_W-1:0] dec_dest;
   logic                  dec_uses_rs;
   logic                  dec_uses_rt;
   logic                  dec_illegal;
   logic [DATA_W-1:0]     dec_imm;
   ctrl_t                 ctrl_q;
   logic                  hazard;
   logic                  accept;

   instr_decoder #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_decoder (
      .instruction (Instruction),
      .ctrl        (dec_ctrl),
      .dest        (dec_dest),
      .uses_rs     (dec_uses_rs),
      .uses_rt     (dec_uses_rt),
      .illegal     (dec_illegal),
      .imm         (dec_imm)
   );

   assign ReadRegister1 = REG_ADDR_W'(Instruction[25:21]);
   assign ReadRegister2 = REG_ADDR_W'(Instruction[20:16]);

   // A load in ID/EX whose destination the incoming word reads must be followed by a bubble.
   assign hazard = InstrValid & OutValid & ctrl_q.mem_read & (OutDest != '0) &
                   ((dec_uses_rs & (OutDest == ReadRegister1)) |
                    (dec_uses_rt & (OutDest == ReadRegister2)));

   assign InstrReady = (!OutValid | OutReady) & !hazard & !Flush;
   assign accept     = InstrValid & InstrReady;

   // ID/EX register: Flush > hazard > accept > drain/hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         OutValid      <= 1'b0;
         ctrl_q        <= CTRL_NONE;
         OutDest       <= '0;
         OutData1      <= '0;
         OutData2      <= '0;
         OutImm        <= '0;
         OutShamt      <= '0;
         OutJumpTarget <= '0;
         IllegalSeen   <= 1'b0;
         StallCount    <= '0;
      end else if (Flush) begin
         // NOTE: non-blocking so every ID/EX field is computed from pre-edge values.
         OutValid <= 1'b0;
         ctrl_q   <= CTRL_NONE;
         OutDest  <= '0;
      end else if (hazard) begin
         if (OutReady) begin
            OutValid <= 1'b0;
            ctrl_q   <= CTRL_NONE;
            OutDest  <= '0;
            if (StallCount != '1) begin
               StallCount <= StallCount + 1'b1;
            end
         end
      end else if (accept) begin
         if (dec_illegal) begin
            OutValid    <= 1'b0;
            ctrl_q      <= CTRL_NONE;
            OutDest     <= '0;
            IllegalSeen <= 1'b1;
         end else begin
            OutValid      <= 1'b1;
            ctrl_q        <= dec_ctrl;
            OutDest       <= dec_dest;
            OutData1      <= ReadData1;
            OutData2      <= ReadData2;
            OutImm        <= dec_imm;
            OutShamt      <= Instruction[10:6];
            OutJumpTarget <= Instruction[25:0];
         end
      end else if (OutReady) begin
         OutValid <= 1'b0;
         ctrl_q   <= CTRL_NONE;
         OutDest  <= '0;
      end
   end

   assign OutRegWrite = ctrl_q.reg_write;
   assign OutMemRead  = ctrl_q.mem_read;
   assign OutMemWrite = ctrl_q.mem_write;
   assign OutMemToReg = ctrl_q.mem_to_reg;
   assign OutAluSrc   = ctrl_q.alu_src;
   assign OutBranch   = ctrl_q.branch;
   assign OutJump     = ctrl_q.jump;
   assign OutAluOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded MIPS words against a small
// register-bank model, with hand-computed ID/EX expectations.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        InstrValid;
   logic [31:0] Instruction;
   logic        InstrReady;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic        Flush;
   logic        OutReady;
   logic        OutValid;
   logic [31:0] OutData1;
   logic [31:0] OutData2;
   logic [31:0] OutImm;
   logic [4:0]  OutShamt;
   logic [4:0]  OutDest;
   logic [2:0]  OutAluOp;
   logic        OutRegWrite;
   logic        OutMemRead;
   logic        OutMemWrite;
   logic        OutMemToReg;
   logic        OutAluSrc;
   logic        OutBranch;
   logic        OutJump;
   logic [25:0] OutJumpTarget;
   logic        IllegalSeen;
   logic [15:0] StallCount;

   logic [31:0] rf [32];
   int          total = 0;
   int          bad   = 0;

   decode_stage dut (
      .clk           (clk),
      .reset         (reset),
      .InstrValid    (InstrValid),
      .Instruction   (Instruction),
      .InstrReady    (InstrReady),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .Flush         (Flush),
      .OutReady      (OutReady),
      .OutValid      (OutValid),
      .OutData1      (OutData1),
      .OutData2      (OutData2),
      .OutImm        (OutImm),
      .OutShamt      (OutShamt),
      .OutDest       (OutDest),
      .OutAluOp      (OutAluOp),
      .OutRegWrite   (OutRegWrite),
      .OutMemRead    (OutMemRead),
      .OutMemWrite   (OutMemWrite),
      .OutMemToReg   (OutMemToReg),
      .OutAluSrc     (OutAluSrc),
      .OutBranch     (OutBranch),
      .OutJump       (OutJump),
      .OutJumpTarget (OutJumpTarget),
      .IllegalSeen   (IllegalSeen),
      .StallCount    (StallCount)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Register-bank model with combinational read.
   always_comb begin
      ReadData1 = rf[ReadRegister1];
      ReadData2 = rf[ReadRegister2];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] word);
      InstrValid  = 1'b1;
      Instruction = word;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      rf[5] = 32'h55;
      reset       = 1'b1;
      InstrValid  = 1'b0;
      Instruction = 32'h0;
      Flush       = 1'b0;
      OutReady    = 1'b1;

      // Reset state.
      #2;
      check("rst_valid", OutValid, 0);
      check("rst_regwrite", OutRegWrite, 0);
      check("rst_dest", OutDest, 0);
      check("rst_stall", StallCount, 0);
      check("rst_illegal", IllegalSeen, 0);
      step();
      reset = 1'b0;
      #1;
      check("rst_ready", InstrReady, 1);

      // add $3,$1,$2
      present(32'h00221820);
      #1;
      check("add_rr1", ReadRegister1, 1);
      check("add_rr2", ReadRegister2, 2);
      check("add_ready", InstrReady, 1);
      step();
      check("add_valid", OutValid, 1);
      check("add_dest", OutDest, 3);
      check("add_aluop", OutAluOp, 0);
      check("add_regwrite", OutRegWrite, 1);
      check("add_data1", OutData1, 5);
      check("add_data2", OutData2, 7);

      // lw $5,4($1) then dependent add $6,$5,$2 -> one bubble.
      present(32'h8C250004);
      step();
      check("lw_valid", OutValid, 1);
      check("lw_memread", OutMemRead, 1);
      check("lw_memtoreg", OutMemToReg, 1);
      check("lw_dest", OutDest, 5);
      check("lw_imm", OutImm, 4);
      present(32'h00A23020);
      #1;
      check("lu_ready", InstrReady, 0);
      step();
      check("lu_bubble_valid", OutValid, 0);
      check("lu_bubble_regwrite", OutRegWrite, 0);
      check("lu_stall", StallCount, 1);
      step();
      check("lu_add_valid", OutValid, 1);
      check("lu_add_dest", OutDest, 6);
      check("lu_add_data1", OutData1, 32'h55);
      check("lu_stall_hold", StallCount, 1);

      // Immediate extension.
      present(32'h2004FFFF);
      step();
      check("addi_imm", OutImm, 32'hFFFFFFFF);
      check("addi_aluop", OutAluOp, 0);
      check("addi_alusrc", OutAluSrc, 1);
      check("addi_dest", OutDest, 4);
      present(32'h3404FFFF);
      step();
      check("ori_imm", OutImm, 32'h0000FFFF);
      check("ori_aluop", OutAluOp, 3);

      // Backpressure: sw waits while ori is held for three cycles.
      present(32'hAC250008);
      OutReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_ready", InstrReady, 0);
         check("bp_valid", OutValid, 1);
         check("bp_imm", OutImm, 32'h0000FFFF);
         check("bp_aluop", OutAluOp, 3);
         check("bp_dest", OutDest, 4);
         check("bp_regwrite", OutRegWrite, 1);
      end
      OutReady = 1'b1;
      #1;
      check("bp_release_ready", InstrReady, 1);
      step();
      check("sw_valid", OutValid, 1);
      check("sw_memwrite", OutMemWrite, 1);
      check("sw_regwrite", OutRegWrite, 0);
      check("sw_dest", OutDest, 0);
      check("sw_imm", OutImm, 8);
      check("sw_data2", OutData2, 32'h55);

      // Flush squashes the accept; the same word loads once flush drops.
      present(32'h00221820);
      Flush = 1'b1;
      #1;
      check("flush_ready", InstrReady, 0);
      step();
      check("flush_valid", OutValid, 0);
      Flush = 1'b0;
      step();
      check("post_flush_valid", OutValid, 1);
      check("post_flush_dest", OutDest, 3);

      // lw $7,0($1): addi $7,$0,1 reads only rs, sub $8,$7,$7 hazards.
      present(32'h8C270000);
      step();
      present(32'h20070001);
      #1;
      check("rt_only_ready", InstrReady, 1);
      present(32'h00E74022);
      #1;
      check("sub_hz_ready", InstrReady, 0);
      OutReady = 1'b0;
      step();
      check("hz_hold_valid", OutValid, 1);
      check("hz_hold_memread", OutMemRead, 1);
      check("hz_hold_stall", StallCount, 1);
      OutReady = 1'b1;
      step();
      check("hz_bubble_valid", OutValid, 0);
      check("hz_stall", StallCount, 2);
      step();
      check("sub_valid", OutValid, 1);
      check("sub_aluop", OutAluOp, 1);
      check("sub_dest", OutDest, 8);
      InstrValid = 1'b0;
      step();
      check("drain_valid", OutValid, 0);

      // beq, j, nop.
      present(32'h10220003);
      step();
      check("beq_branch", OutBranch, 1);
      check("beq_aluop", OutAluOp, 1);
      check("beq_imm", OutImm, 3);
      check("beq_regwrite", OutRegWrite, 0);
      present(32'h08000010);
      step();
      check("j_jump", OutJump, 1);
      check("j_target", OutJumpTarget, 26'h10);
      present(32'h00000000);
      step();
      check("nop_valid", OutValid, 1);
      check("nop_regwrite", OutRegWrite, 0);
      check("nop_jump", OutJump, 0);

      // Illegal opcode becomes a bubble and sets the sticky flag.
      present(32'hFC000000);
      step();
      check("ill_valid", OutValid, 0);
      check("ill_seen", IllegalSeen, 1);
      present(32'h00221820);
      step();
      check("ill_next_valid", OutValid, 1);
      check("ill_sticky", IllegalSeen, 1);

      // Asynchronous reset mid-stream.
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", OutValid, 0);
      check("mid_rst_regwrite", OutRegWrite, 0);
      check("mid_rst_dest", OutDest, 0);
      check("mid_rst_illegal", IllegalSeen, 0);
      check("mid_rst_stall", StallCount, 0);
      check("mid_rst_data1", OutData1, 0);
      InstrValid = 1'b0;
      step();
      reset = 1'b0;
      #1;
      check("mid_rst_ready", InstrReady, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
